// File: rtl/regfile_write_ctrl_if.sv
// Write-port bundle between the WB/LD requesters and the register file.
// The requester side drives requests; the controller side answers and drives the array.
interface regfile_write_ctrl_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic              WbValid;
    logic [ADDR_W-1:0] WbAddr;
    logic [DATA_W-1:0] WbData;
    logic              WbReady;
    logic              LdValid;
    logic [ADDR_W-1:0] LdAddr;
    logic [DATA_W-1:0] LdData;
    logic              LdReady;
    logic [ADDR_W-1:0] AddrD;
    logic [DATA_W-1:0] DataD;
    logic              RegWEn;
    logic              InitDone;

    modport master (
        output WbValid, WbAddr, WbData,
        output LdValid, LdAddr, LdData,
        input  WbReady, LdReady,
        input  AddrD, DataD, RegWEn, InitDone
    );

    modport slave (
        input  WbValid, WbAddr, WbData,
        input  LdValid, LdAddr, LdData,
        output WbReady, LdReady,
        output AddrD, DataD, RegWEn, InitDone
    );
endinterface

// File: rtl/regfile_write_ctrl.sv
// Register file write-port owner: post-reset zero sweep, then WB/LD arbitration
// with fixed WB priority and a stall-count guard that forces an LD grant.
module regfile_write_ctrl #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input logic               Clk,
    input logic               Rst,
    regfile_write_ctrl_if.slave Bus
);
    typedef enum logic {CLEAR, RUN} state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);
    localparam logic [3:0]        WAIT_LIM = 4'(MAX_WAIT);

    state_t            state, stateNext;
    logic [ADDR_W-1:0] clrIdx, clrIdxNext;
    logic [3:0]        ldWait, ldWaitNext;
    logic              weQ, weNext;
    logic [ADDR_W-1:0] addrQ, addrNext;
    logic [DATA_W-1:0] dataQ, dataNext;

    logic inRun;
    logic forceLd;
    logic wbAcc;
    logic ldAcc;

    assign inRun   = !Rst && (state == RUN);
    assign forceLd = (ldWait >= WAIT_LIM);

    assign Bus.WbReady  = inRun && !forceLd;
    assign Bus.LdReady  = inRun && (forceLd || !Bus.WbValid);
    assign Bus.InitDone = inRun;
    assign Bus.RegWEn   = weQ;
    assign Bus.AddrD    = addrQ;
    assign Bus.DataD    = dataQ;

    assign wbAcc = Bus.WbValid && Bus.WbReady;
    assign ldAcc = Bus.LdValid && Bus.LdReady;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state  <= CLEAR;
            clrIdx <= '0;
            ldWait <= '0;
            weQ    <= 1'b0;
            addrQ  <= '0;
            dataQ  <= '0;
        end else begin
            state  <= stateNext;
            clrIdx <= clrIdxNext;
            ldWait <= ldWaitNext;
            weQ    <= weNext;
            addrQ  <= addrNext;
            dataQ  <= dataNext;
        end
    end

    always_comb begin
        stateNext  = state;
        clrIdxNext = clrIdx;
        weNext     = 1'b0;
        addrNext   = addrQ;
        dataNext   = dataQ;
        unique case (state)
            CLEAR: begin
                weNext     = 1'b1;
                addrNext   = clrIdx;
                dataNext   = '0;
                clrIdxNext = clrIdx + 1'b1;
                if (clrIdx == LAST_IDX) begin
                    stateNext = RUN;
                end
            end
            RUN: begin
                // x0 requests are consumed but never reach the array
                if (wbAcc) begin
                    if (|Bus.WbAddr) begin
                        weNext   = 1'b1;
                        addrNext = Bus.WbAddr;
                        dataNext = Bus.WbData;
                    end
                end else if (ldAcc) begin
                    if (|Bus.LdAddr) begin
                        weNext   = 1'b1;
                        addrNext = Bus.LdAddr;
                        dataNext = Bus.LdData;
                    end
                end
            end
            default: stateNext = CLEAR;
        endcase
    end

    always_comb begin
        ldWaitNext = ldWait;
        if (!Bus.LdValid || ldAcc) begin
            ldWaitNext = '0;
        end else if (ldWait != 4'hF) begin
            ldWaitNext = ldWait + 4'd1;
        end
    end
endmodule
